// File: rtl/pll_reset_seq.sv
// pll_reset_seq: waits for a stable PLL lock, releases the memory reset and
// then the system reset, pulses the PLL reset on lock timeout, and generates
// the 14 / 7 / 3.5 MHz clock-enable strobes from the 28 MHz PLL clock.
module pll_reset_seq #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int PULSE_CYCLES   = 16,
  parameter int STAGE_GAP      = 16
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic ext_reset,
  output logic pll_rst,
  output logic rst_mem,
  output logic rst_sys,
  output logic ready,
  output logic ce_14,
  output logic ce_7,
  output logic ce_3_5
);

  // One counter serves every timed state, so it is sized for the longest one.
  localparam int MAX_LT  = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_LTP = (MAX_LT > PULSE_CYCLES) ? MAX_LT : PULSE_CYCLES;
  localparam int CNT_MAX = (MAX_LTP > STAGE_GAP) ? MAX_LTP : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_PLL_RST   = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_MEM   = 3'd3,
    S_RUN       = 3'd4,
    S_SYS_RST   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_adv;

  logic [1:0]       r_sync;
  logic             w_lock_s;

  logic             w_pll_rst_nx;
  logic             w_rst_mem_nx;
  logic             w_rst_sys_nx;
  logic             w_ready_nx;

  logic             r_pll_rst;
  logic             r_rst_mem;
  logic             r_rst_sys;
  logic             r_ready;
  logic [2:0]       r_div;
  logic             r_ce_14;
  logic             r_ce_7;
  logic             r_ce_3_5;

  assign w_lock_s = r_sync[1];

  // Two-flop synchronizer bringing the asynchronous lock flag into clk_sys
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
    end
  end

  // State register plus the shared counter, which clears on every state entry
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_cnt_adv) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic: lock loss outranks ext_reset and every counter terminal
  always_comb begin
    w_state_next = r_state;
    w_cnt_adv    = 1'b0;
    case (r_state)
      S_WAIT_LOCK: begin
        if (w_lock_s)                   w_state_next = S_STABLE;
        else if (r_cnt == TIMEOUT_LAST) w_state_next = S_PLL_RST;
        else                            w_cnt_adv    = 1'b1;
      end
      S_PLL_RST: begin
        // Lock is deliberately ignored until the pulse has completed
        if (r_cnt == PULSE_LAST) w_state_next = S_WAIT_LOCK;
        else                     w_cnt_adv    = 1'b1;
      end
      S_STABLE: begin
        if (!w_lock_s)               w_state_next = S_WAIT_LOCK;
        else if (r_cnt == LOCK_LAST) w_state_next = S_REL_MEM;
        else                         w_cnt_adv    = 1'b1;
      end
      S_REL_MEM: begin
        if (!w_lock_s)              w_state_next = S_WAIT_LOCK;
        else if (r_cnt == GAP_LAST) w_state_next = S_RUN;
        else                        w_cnt_adv    = 1'b1;
      end
      S_RUN: begin
        if (!w_lock_s)      w_state_next = S_WAIT_LOCK;
        else if (ext_reset) w_state_next = S_SYS_RST;
      end
      S_SYS_RST: begin
        // A still-asserted request parks the counter at its terminal value
        if (!w_lock_s) begin
          w_state_next = S_WAIT_LOCK;
        end else if (r_cnt == GAP_LAST) begin
          if (!ext_reset) w_state_next = S_RUN;
        end else begin
          w_cnt_adv = 1'b1;
        end
      end
      default: w_state_next = S_WAIT_LOCK;
    endcase
  end

  // Output decode: resets and ready follow the current state one edge later,
  // while the PLL pulse is aligned with entry to and exit from PLL_RST
  always_comb begin
    w_pll_rst_nx = (w_state_next == S_PLL_RST);
    w_rst_mem_nx = !((r_state == S_REL_MEM) || (r_state == S_RUN) || (r_state == S_SYS_RST));
    w_rst_sys_nx = (r_state != S_RUN);
    w_ready_nx   = (r_state == S_RUN);
  end

  // Registered reset and ready outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst <= 1'b0;
      r_rst_mem <= 1'b1;
      r_rst_sys <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_pll_rst <= w_pll_rst_nx;
      r_rst_mem <= w_rst_mem_nx;
      r_rst_sys <= w_rst_sys_nx;
      r_ready   <= w_ready_nx;
    end
  end

  // Clock-enable divider; strobes drop on the same edge rst_sys rises
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= 3'd0;
      r_ce_14  <= 1'b0;
      r_ce_7   <= 1'b0;
      r_ce_3_5 <= 1'b0;
    end else begin
      if (r_rst_sys || w_rst_sys_nx) begin
        r_div <= 3'd0;
      end else begin
        r_div <= r_div + 3'd1;
      end
      if (w_rst_sys_nx) begin
        r_ce_14  <= 1'b0;
        r_ce_7   <= 1'b0;
        r_ce_3_5 <= 1'b0;
      end else begin
        r_ce_14  <= r_div[0];
        r_ce_7   <= (r_div[1:0] == 2'b11);
        r_ce_3_5 <= (r_div == 3'b111);
      end
    end
  end

  assign pll_rst = r_pll_rst;
  assign rst_mem = r_rst_mem;
  assign rst_sys = r_rst_sys;
  assign ready   = r_ready;
  assign ce_14   = r_ce_14;
  assign ce_7    = r_ce_7;
  assign ce_3_5  = r_ce_3_5;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed scenarios; expected output changes are queued as
// stimulus is issued and a negedge monitor matches every change it observes.
module tb_pll_reset_seq;

  logic clk_sys    = 1'b0;
  logic rst_n      = 1'b0;
  logic pll_locked = 1'b0;
  logic ext_reset  = 1'b0;
  logic pll_rst, rst_mem, rst_sys, ready, ce_14, ce_7, ce_3_5;

  pll_reset_seq #(
    .LOCK_CYCLES   (8),
    .TIMEOUT_CYCLES(64),
    .PULSE_CYCLES  (4),
    .STAGE_GAP     (4)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .ext_reset (ext_reset),
    .pll_rst   (pll_rst),
    .rst_mem   (rst_mem),
    .rst_sys   (rst_sys),
    .ready     (ready),
    .ce_14     (ce_14),
    .ce_7      (ce_7),
    .ce_3_5    (ce_3_5)
  );

  initial forever #5 clk_sys = ~clk_sys;

  // Edge counter: value at a negedge is the index of the latest posedge
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Control vector order: {pll_rst, rst_mem, rst_sys, ready}
  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  typedef struct {
    string      name;
    logic [6:0] got;
    logic [6:0] exp;
  } snap_t;

  ev_t   ctrl_q[$];
  int    ce14_q[$];
  int    ce7_q[$];
  int    ce35_q[$];
  snap_t snap_q[$];

  int   tests  = 0;
  int   fails  = 0;
  logic mon_en = 1'b0;
  logic done   = 1'b0;
  logic [3:0] prev = 4'b0110;

  task automatic push_ctrl(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    ctrl_q.push_back(e);
  endtask

  // Strobe pulses after rst_sys falls at edge f, up to and including edge last
  task automatic exp_run(input int f, input int last);
    for (int k = f + 2; k <= last; k += 2) begin
      ce14_q.push_back(k);
      if (((k - f) % 4) == 0) ce7_q.push_back(k);
      if (((k - f) % 8) == 0) ce35_q.push_back(k);
    end
  endtask

  task automatic snap(input string nm, input logic [6:0] ex);
    snap_t s;
    s.name = nm;
    s.got  = {pll_rst, rst_mem, rst_sys, ready, ce_14, ce_7, ce_3_5};
    s.exp  = ex;
    snap_q.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_sys);
  endtask

  // Monitor: every output change or strobe is matched against the queues
  always @(negedge clk_sys) begin : monitor
    logic [3:0] cur;
    ev_t        e;
    snap_t      s;
    int         c;
    if (mon_en) begin
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        tests++;
        if (s.got !== s.exp) begin
          fails++;
          $display("FAIL %s got=%b required=%b", s.name, s.got, s.exp);
        end else begin
          $display("[TB] %s ok outputs=%b", s.name, s.got);
        end
      end
      cur = {pll_rst, rst_mem, rst_sys, ready};
      if (cur !== prev) begin
        tests++;
        if (ctrl_q.size() == 0) begin
          fails++;
          $display("FAIL ctrl_change cyc=%0d got=%b required no change from %b", cyc, cur, prev);
        end else begin
          e = ctrl_q.pop_front();
          if ((e.cyc != cyc) || (e.val !== cur)) begin
            fails++;
            $display("FAIL ctrl_change got cyc=%0d val=%b required cyc=%0d val=%b", cyc, cur, e.cyc, e.val);
          end else begin
            $display("[TB] ctrl cyc=%0d {pll_rst,rst_mem,rst_sys,ready}=%b ok", cyc, cur);
          end
        end
        prev = cur;
      end
      if (ce_14 === 1'b1) begin
        tests++;
        if (ce14_q.size() == 0) begin
          fails++;
          $display("FAIL ce_14_pulse got pulse at cyc=%0d required none", cyc);
        end else begin
          c = ce14_q.pop_front();
          if (c != cyc) begin
            fails++;
            $display("FAIL ce_14_pulse got cyc=%0d required cyc=%0d", cyc, c);
          end else begin
            $display("[TB] ce_14 cyc=%0d ok", cyc);
          end
        end
      end
      if (ce_7 === 1'b1) begin
        tests++;
        if (ce7_q.size() == 0) begin
          fails++;
          $display("FAIL ce_7_pulse got pulse at cyc=%0d required none", cyc);
        end else begin
          c = ce7_q.pop_front();
          if (c != cyc) begin
            fails++;
            $display("FAIL ce_7_pulse got cyc=%0d required cyc=%0d", cyc, c);
          end else begin
            $display("[TB] ce_7 cyc=%0d ok", cyc);
          end
        end
      end
      if (ce_3_5 === 1'b1) begin
        tests++;
        if (ce35_q.size() == 0) begin
          fails++;
          $display("FAIL ce_3_5_pulse got pulse at cyc=%0d required none", cyc);
        end else begin
          c = ce35_q.pop_front();
          if (c != cyc) begin
            fails++;
            $display("FAIL ce_3_5_pulse got cyc=%0d required cyc=%0d", cyc, c);
          end else begin
            $display("[TB] ce_3_5 cyc=%0d ok", cyc);
          end
        end
      end
      if (done) begin
        tests++;
        if (ctrl_q.size() != 0) begin
          fails++;
          $display("FAIL ctrl_pending got %0d unmatched, first cyc=%0d, required 0", ctrl_q.size(), ctrl_q[0].cyc);
        end
        tests++;
        if ((ce14_q.size() + ce7_q.size() + ce35_q.size()) != 0) begin
          fails++;
          $display("FAIL ce_pending got %0d/%0d/%0d unmatched, required 0", ce14_q.size(), ce7_q.size(), ce35_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin : stim
    int e, f, r, l, w, c;

    // Reset state
    tick(3);
    snap("reset_state", 7'b0110000);
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // Clean start: lock rises 5 cycles after reset release
    tick(5);
    e = cyc + 1;
    pll_locked = 1'b1;
    f = e + 15;
    r = f + 21;
    push_ctrl(e + 11, 4'b0010);
    push_ctrl(f,      4'b0001);
    // One-cycle user reset in RUN
    push_ctrl(r + 1,  4'b0010);
    push_ctrl(r + 5,  4'b0001);
    exp_run(f, r);
    wait_cyc(r - 1);
    ext_reset = 1'b1;
    tick(1);
    ext_reset = 1'b0;

    // Ten-cycle user reset holds rst_sys until after its fall
    f = r + 5;
    r = f + 12;
    push_ctrl(r + 1,  4'b0010);
    push_ctrl(r + 11, 4'b0001);
    exp_run(f, r);
    wait_cyc(r - 1);
    ext_reset = 1'b1;
    tick(10);
    ext_reset = 1'b0;

    // Lock loss in RUN, then relock with ext_reset pulsed during STABLE
    f = r + 11;
    l = f + 13;
    exp_run(f, l + 2);
    push_ctrl(l + 3, 4'b0110);
    wait_cyc(l - 1);
    pll_locked = 1'b0;
    e = l + 5;
    wait_cyc(e - 1);
    pll_locked = 1'b1;
    f = e + 15;
    push_ctrl(e + 11, 4'b0010);
    push_ctrl(f,      4'b0001);
    wait_cyc(e + 1);
    ext_reset = 1'b1;
    wait_cyc(e + 7);
    ext_reset = 1'b0;

    // Unstable lock: 5 high, 2 low, then high for good
    l = f + 9;
    exp_run(f, l + 2);
    push_ctrl(l + 3, 4'b0110);
    wait_cyc(l - 1);
    pll_locked = 1'b0;
    wait_cyc(l + 3);
    pll_locked = 1'b1;
    wait_cyc(l + 8);
    pll_locked = 1'b0;
    wait_cyc(l + 10);
    pll_locked = 1'b1;
    e = l + 11;
    f = e + 15;
    push_ctrl(e + 11, 4'b0010);
    push_ctrl(f,      4'b0001);

    // No lock: pll_rst pulses 4 wide every 68 cycles
    l = f + 10;
    exp_run(f, l + 2);
    push_ctrl(l + 3, 4'b0110);
    w = l + 2;
    push_ctrl(w + 64,  4'b1110);
    push_ctrl(w + 68,  4'b0110);
    push_ctrl(w + 132, 4'b1110);
    push_ctrl(w + 136, 4'b0110);
    push_ctrl(w + 200, 4'b1110);
    wait_cyc(l - 1);
    pll_locked = 1'b0;

    // Asynchronous reset in the middle of the third pulse
    wait_cyc(w + 201);
    #2;
    rst_n = 1'b0;
    push_ctrl(w + 202, 4'b0110);
    #1;
    snap("async_reset_drop", 7'b0110000);
    tick(3);
    rst_n = 1'b1;
    c = cyc;
    // Back in WAIT_LOCK with a cleared counter: timeout counts from release
    push_ctrl(c + 64, 4'b1110);
    push_ctrl(c + 68, 4'b0110);
    wait_cyc(c + 72);
    done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no completion by %0t required completion", $time);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Lock-qualifying reset sequencer and clock-enable generator that sits directly downstream of the system PLL. It runs on the 28 MHz PLL output and watches the PLL `locked` flag. It releases a memory-domain reset and then a system reset only after lock has been stable for a programmable time, and it retries the PLL on lock timeout. Once running, it produces the 14/7/3.5 MHz clock-enable strobes used by the CPU and peripheral logic.

## Interface
Parameters:
- `LOCK_CYCLES`, default 1024: consecutive synchronized-lock cycles required before releasing `rst_mem`.
- `TIMEOUT_CYCLES`, default 1048576: cycles spent waiting for lock before a PLL reset pulse is issued.
- `PULSE_CYCLES`, default 16: width of the `pll_rst` pulse.
- `STAGE_GAP`, default 16: cycles between `rst_mem` release and `rst_sys` release; also the width of a user-requested system reset.

Ports (clock and reset first):
- `clk_sys`, in, 1: 28 MHz clock. This is the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pll_locked`, in, 1: PLL lock flag, asynchronous to `clk_sys`.
- `ext_reset`, in, 1: user reset request, synchronous, level-sensitive.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `rst_mem`, out, 1: active-high reset for SDRAM/memory logic.
- `rst_sys`, out, 1: active-high reset for the CPU/system.
- `ready`, out, 1: high only in RUN.
- `ce_14`, `ce_7`, `ce_3_5`, out, 1 each: single-cycle clock-enable strobes.

All outputs are registered.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lock_s`.
- There is one shared counter `cnt`, sized to the largest parameter. It clears on every state entry.
- Reset state while `rst_n` is low:
  - state = WAIT_LOCK.
  - `cnt`, the divider and `pll_rst` = 0.
  - `rst_mem` = `rst_sys` = 1.
  - `ready` = 0; all `ce_*` = 0.

States and transitions:
- **WAIT_LOCK**:
  - `rst_mem` = `rst_sys` = 1.
  - If `lock_s` is high, go to STABLE.
  - Else if `cnt` = TIMEOUT_CYCLES-1, go to PLL_RST.
  - Else `cnt`++.
- **PLL_RST**:
  - `pll_rst` = 1.
  - `lock_s` is ignored.
  - At `cnt` = PULSE_CYCLES-1, go to WAIT_LOCK with `pll_rst` = 0.
- **STABLE**:
  - If `lock_s` is low, go to WAIT_LOCK.
  - Else if `cnt` = LOCK_CYCLES-1, go to REL_MEM.
  - Else `cnt`++.
- **REL_MEM**:
  - `rst_mem` = 0.
  - If `lock_s` is low, go to WAIT_LOCK.
  - Else at `cnt` = STAGE_GAP-1, go to RUN.
- **RUN**:
  - `rst_sys` = 0 and `ready` = 1.
  - If `lock_s` is low, go to WAIT_LOCK.
  - Else if `ext_reset` is high, go to SYS_RST.
- **SYS_RST**:
  - `rst_sys` = 1, `rst_mem` stays 0, `ready` = 0.
  - If `lock_s` is low, go to WAIT_LOCK.
  - Else at `cnt` = STAGE_GAP-1 and with `ext_reset` low, go to RUN.
  - If `ext_reset` is still high, hold `cnt` at STAGE_GAP-1 and stay in SYS_RST.

Priority and boundary rules:
- Lock loss beats `ext_reset` and beats any counter terminal condition.
- `ext_reset` is ignored outside RUN and SYS_RST.
- Entry to WAIT_LOCK from any state asserts `rst_mem` and `rst_sys`, and drops `ready` and all `ce_*`, on the same edge.

Clock-enable divider:
- 3-bit free-running counter `div`. It is held at 0 whenever `rst_sys` = 1 and increments by 1 (mod 8) otherwise.
- `ce_14` = 1 when `div[0]` = 1.
- `ce_7` = 1 when `div[1:0]` = 3.
- `ce_3_5` = 1 when `div` = 7.
- All strobes are registered and forced to 0 while `rst_sys` = 1.

## Timing
Lock qualification:
- Let E be the first `clk_sys` edge that samples `pll_locked` high, with lock held stable afterwards.
- `rst_mem` falls exactly LOCK_CYCLES+3 edges after E.
- `rst_sys` and `ready` change STAGE_GAP edges after that.

Lock loss:
- `pll_locked` sampled low at edge L causes `rst_mem` = `rst_sys` = 1 and `ready` = 0 at edge L+3.
- The 3 edges are the 2 synchronizer stages plus the state register.
- A glitch shorter than one cycle may be missed; a glitch of 2 or more cycles must never be missed.

Timeout:
- `pll_rst` rises TIMEOUT_CYCLES edges after WAIT_LOCK entry.
- `pll_rst` stays high for exactly PULSE_CYCLES cycles.
- WAIT_LOCK then restarts with `cnt` = 0.

Clock enables after `rst_sys` falls:
- First `ce_14` at the 2nd edge after the fall, then every 2 cycles.
- First `ce_7` at the 4th edge, then every 4 cycles.
- First `ce_3_5` at the 8th edge, then every 8 cycles.
- `ce_14`, `ce_7` and `ce_3_5` coincide whenever `ce_3_5` is high.

User reset:
- `ext_reset` high at edge R gives `rst_sys` = 1 at R+1.
- After `ext_reset` falls, `rst_sys` = 0 no earlier than STAGE_GAP cycles after R+1.

Asynchronous reset:
- Assertion of `rst_n` takes effect immediately in any state, including mid-PULSE.
- Deassertion is assumed synchronized upstream.

## Test plan
Benches use LOCK_CYCLES=8, TIMEOUT_CYCLES=64, PULSE_CYCLES=4, STAGE_GAP=4.

1. **Clean start**: raise `pll_locked` 5 cycles after reset release.
   - `rst_mem` falls 11 edges after the first sampling edge; `rst_sys` and `ready` follow 4 edges later.
   - `ce_14`, `ce_7` and `ce_3_5` periods are 2/4/8 cycles.
2. **Unstable lock**: hold lock high 5 cycles, low 2 cycles, then high.
   - STABLE aborts and the count restarts.
   - `rst_mem` falls 11 edges after the final rising sample.
3. **No lock**: hold `pll_locked` at 0.
   - `pll_rst` pulses for 4 cycles every 68 cycles (64 waiting + 4 pulse).
   - `rst_mem` and `rst_sys` stay at 1 throughout.
4. **Lock loss in RUN**: drop `pll_locked` at edge L.
   - At L+3: `rst_mem` = `rst_sys` = 1, `ready` = 0, `ce_*` = 0.
   - Relock repeats the full sequence from scenario 1.
5. **User reset**:
   - 1-cycle `ext_reset` in RUN gives `rst_sys` high for exactly 4 cycles with `rst_mem` staying 0 and the divider restarting.
   - A 10-cycle `ext_reset` holds `rst_sys` high until its fall.
   - `ext_reset` during STABLE has no effect.
6. **Async reset mid-PLL_RST**: pulse `rst_n` low during the `pll_rst` pulse.
   - `pll_rst` drops immediately.
   - `rst_mem` = `rst_sys` = 1 and the state returns to WAIT_LOCK.
